encode_pack: RTL and testbench
==============================

Name: encode_pack

Overview:
- Parametrised successor to the LZS encoder's output stage.
- Packs variable-length codes (1..CODE_W bits, MSB-first) from the encode controller into fixed OUT_W-bit words for the output FIFO.
- Adds generic widths, valid/ready input handshake, FIFO backpressure via fo_full, optional LZS end-marker insertion, zero padding on flush, and an emitted-word counter.

Parameters:
- OUT_W, 16, output word width in bits; must be ≥ CODE_W.
- CODE_W, 13, maximum code width.
- LEN_W, 4, width of code_len; 2^LEN_W > CODE_W.
- END_MARK, 1, 1 = append the 9-bit LZS end marker 9'b110000000 on flush; 0 = no marker.
- CNT_W, 16, width of word_cnt.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- ce, input, 1, clock enable; when low, all state holds.
- code_valid, input, 1, a code is offered.
- code_data, input, CODE_W, code bits, right-aligned; bits at and above code_len are ignored.
- code_len, input, LEN_W, number of valid bits; 0 = no-op; values > CODE_W are clamped to CODE_W.
- flush, input, 1, end of stream; qualified like code_valid.
- code_ready, output, 1, code and flush are accepted on a clk edge where valid && code_ready && ce.
- fo_full, input, 1, output FIFO full; a word transfers when valid_o && !fo_full && ce.
- data_o, output, OUT_W, packed word; the first-received bit is at the MSB.
- valid_o, output, 1, data_o holds a word.
- done_o, output, 1, one-cycle pulse after the final word has transferred.
- word_cnt, output, CNT_W, number of words transferred since reset; wraps.
- encode_out_state, output, 3, FSM state for debug.

Behaviour:
One clock, clk. Reset is synchronous and active-high on rst; the clock and reset ports are named clk and rst.

Reset values:
- data_o = 0, valid_o = 0, done_o = 0, word_cnt = 0.
- Accumulator cleared, bit count cnt = 0.
- State = RUN (0), code_ready = 1.
- Reset mid-operation discards all buffered bits and any pending word.

Data path:
- Accumulator width is ACC_W = OUT_W + CODE_W; cnt is the number of valid bits, left-aligned.
- code_ready = (state == RUN) && (cnt < OUT_W). This guarantees no overflow.
- Append: acc |= masked code << (ACC_W − cnt − len); cnt += len.
- Emit when cnt ≥ OUT_W and the output register is free (!valid_o || !fo_full):
  - data_o ← acc[ACC_W−1 -: OUT_W]; valid_o ← 1.
  - acc shifts left by OUT_W; cnt −= OUT_W.
- Emit and append in the same cycle are both applied: cnt_next = cnt − OUT_W + len, and the new code is placed relative to the post-shift cnt.
- Latency: a word completed at edge N appears on data_o with valid_o at edge N+1 if the register is free.
- When a word transfers and no new word loads, valid_o ← 0.
- word_cnt increments on each transfer.
- While fo_full = 1, data_o and valid_o are held stable and no bits are lost.

FSM:
- RUN (0):
  - Accepts codes.
  - Accepted flush: any code accepted on the same edge is packed first, then go to MARK if END_MARK = 1, else PAD.
- MARK (1): when cnt < OUT_W, append the 9-bit marker, then go to PAD.
- PAD (2):
  - cnt == 0: go to DRAIN.
  - 0 < cnt < OUT_W: zero-fill by setting cnt = OUT_W; the normal emit path sends the word; go to DRAIN once cnt == 0.
  - cnt ≥ OUT_W: emit normally first.
- DRAIN (3): wait for valid_o == 0, then go to DONE.
- DONE (4): done_o = 1 for exactly one cycle, then go to RUN with code_ready = 1.
- code_ready = 0 in every state except RUN.
- Flush with an empty accumulator and END_MARK = 0: no word is produced; done_o pulses 3 cycles after flush acceptance (PAD → DRAIN → DONE).

ce behaviour: ce low freezes the FSM, accumulator, outputs and counters. A done_o pulse is held until ce returns high.

Test Plan:
(OUT_W = 16, CODE_W = 13, END_MARK = 1 unless stated; all values hex.)
1. Reset -> data_o = 0, valid_o = 0, done_o = 0, code_ready = 1, encode_out_state = 0, word_cnt = 0.
2. Two codes, fo_full = 0:
   - Stimulus: code 1AB (len 9), then 0CD (len 9), then flush.
   - Required: word D5B3, then 7000 (remainder "01", marker, zero pad); done_o pulses once after the second transfer; word_cnt = 2.
3. Backpressure:
   - Stimulus: same codes, fo_full = 1 for 10 cycles after valid_o first rises.
   - Required: data_o stays D5B3 with valid_o = 1; code_ready = 0 while cnt ≥ 16 and the register is full; final words identical to scenario 2.
4. Empty flush, END_MARK = 0:
   - Stimulus: flush with no codes.
   - Required: valid_o never rises; done_o pulses 3 cycles after acceptance; word_cnt unchanged.
5. Reset mid-stream:
   - Stimulus: rst high for one cycle while in DRAIN with valid_o = 1.
   - Required: all outputs return to reset values; next code 1FFF (len 13) plus 000 (len 3) yields word FFF8.
6. Clock enable and clamping:
   - Stimulus: ce low for 5 cycles mid-stream; also code_len = 15 applied.
   - Required: outputs frozen during ce low; len 15 is treated as 13 bits; code_len = 0 leaves cnt unchanged.

Source files
------------

// File: rtl/encode_pack.sv
// encode_pack: packs MSB-first variable-length codes into OUT_W-bit words,
// with flush, optional LZS end marker, zero padding and FIFO backpressure.
module encode_pack #(
  parameter int OUT_W    = 16,
  parameter int CODE_W   = 13,
  parameter int LEN_W    = 4,
  parameter bit END_MARK = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_data,
  input  logic [LEN_W-1:0]  code_len,
  input  logic              flush,
  output logic              code_ready,
  input  logic              fo_full,
  output logic [OUT_W-1:0]  data_o,
  output logic              valid_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [2:0]        encode_out_state
);
  localparam int ACC_W = OUT_W + CODE_W;
  localparam int CW = $clog2(ACC_W + 1);
  typedef enum logic [2:0] {RUN, MARK, PAD, DRAIN, DONE} state_t;
  state_t st_q, st_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_s, app;
  logic [CW-1:0] cnt_q, cnt_d, cnt_s, ln;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [LEN_W-1:0] len_c;
  logic valid_q, valid_d, done_q, done_d;
  logic xfer, emit, take, mark, fill;
  always_comb begin
    code_ready = st_q == RUN && cnt_q < CW'(OUT_W);
    xfer = valid_q && !fo_full;
    emit = cnt_q >= CW'(OUT_W) && (!valid_q || !fo_full);
    take = code_ready && code_valid;
    mark = st_q == MARK && cnt_q < CW'(OUT_W);
    fill = st_q == PAD && cnt_q != '0 && cnt_q < CW'(OUT_W);
    len_c = code_len > LEN_W'(CODE_W) ? LEN_W'(CODE_W) : code_len;
    ln = mark ? CW'(9) : take ? CW'(len_c) : '0;
    app = mark ? ACC_W'(9'h180) : take ? ACC_W'(code_data & ~({CODE_W{1'b1}} << len_c)) : '0;
    // new bits land just below the valid bits remaining after this cycle's emit
    cnt_s = emit ? cnt_q - CW'(OUT_W) : cnt_q;
    acc_s = emit ? acc_q << OUT_W : acc_q;
    acc_d = acc_s | (app << (CW'(ACC_W) - cnt_s - ln));
    cnt_d = fill ? CW'(OUT_W) : cnt_s + ln;
    data_d = emit ? acc_q[ACC_W-1 -: OUT_W] : data_q;
    valid_d = emit || (valid_q && !xfer);
    done_d = st_q == DONE;
    wcnt_d = wcnt_q + CNT_W'(xfer);
    st_d = st_q;
    case (st_q)
      RUN:     if (code_ready && flush) st_d = END_MARK ? MARK : PAD;
      MARK:    if (mark) st_d = PAD;
      PAD:     if (cnt_q == '0) st_d = DRAIN;
      DRAIN:   if (!valid_q) st_d = DONE;
      default: st_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= RUN;
      acc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      wcnt_q <= '0;
    end else if (ce) begin
      st_q <= st_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
      wcnt_q <= wcnt_d;
    end
  end
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign done_o = done_q;
  assign word_cnt = wcnt_q;
  assign encode_out_state = st_q;
endmodule

// File: tb/tb_encode_pack.sv
// tb_encode_pack: vector table, directed corner sequences and randomized traffic
// checked against a bit-queue reference model of the packed output stream.
module tb_encode_pack;
  logic clk = 1'b0, rst = 1'b0, ce = 1'b1, code_valid = 1'b0, flush = 1'b0, fo_full = 1'b0;
  logic [12:0] code_data = '0;
  logic [3:0] code_len = '0;
  logic code_ready, valid_o, done_o, ready1, valid1, done1;
  logic [15:0] data_o, word_cnt, data1, wcnt1;
  logic [2:0] encode_out_state, st1;
  always #5 clk = ~clk;

  encode_pack u0 (.clk(clk), .rst(rst), .ce(ce), .code_valid(code_valid), .code_data(code_data),
    .code_len(code_len), .flush(flush), .code_ready(code_ready), .fo_full(fo_full), .data_o(data_o),
    .valid_o(valid_o), .done_o(done_o), .word_cnt(word_cnt), .encode_out_state(encode_out_state));
  encode_pack #(.END_MARK(1'b0)) u1 (.clk(clk), .rst(rst), .ce(ce), .code_valid(code_valid),
    .code_data(code_data), .code_len(code_len), .flush(flush), .code_ready(ready1), .fo_full(fo_full),
    .data_o(data1), .valid_o(valid1), .done_o(done1), .word_cnt(wcnt1), .encode_out_state(st1));

  int n_cmp = 0, n_bad = 0;
  bit bq[$];
  logic [15:0] ew[$];
  logic [15:0] mwc = '0;

  typedef struct packed {
    logic cv; logic [12:0] cd; logic [3:0] cl; logic fl; logic ff;
    logic [15:0] data; logic valid, done, ready; logic [2:0] st; logic [15:0] wc;
  } vec_t;
  vec_t tv[11];

  function automatic logic [37:0] stat();
    return {data_o, valid_o, done_o, code_ready, encode_out_state, word_cnt};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pack();
    while (bq.size() >= 16) begin
      logic [15:0] w;
      for (int i = 15; i >= 0; i--) w[i] = bq.pop_front();
      ew.push_back(w);
    end
  endtask

  task automatic push_code(input logic [12:0] d, input logic [3:0] l);
    int n;
    n = (l > 4'd13) ? 13 : int'(l);
    for (int i = n - 1; i >= 0; i--) bq.push_back(d[i]);
    pack();
  endtask

  task automatic do_flush();
    logic [8:0] m;
    m = 9'h180;
    for (int i = 8; i >= 0; i--) bq.push_back(m[i]);
    while (bq.size() % 16 != 0) bq.push_back(1'b0);
    pack();
  endtask

  task automatic drv(input logic cv, input logic [12:0] cd, input logic [3:0] cl,
                     input logic fl, input logic ff, input logic c);
    code_valid = cv; code_data = cd; code_len = cl; flush = fl; fo_full = ff; ce = c;
  endtask

  // one clock: model the handshakes seen just before the edge, then check after it
  task automatic cyc();
    #1;
    if (rst) begin
      bq.delete(); ew.delete(); mwc = '0;
    end else if (ce) begin
      if (code_valid && code_ready) push_code(code_data, code_len);
      if (flush && code_ready) do_flush();
      if (valid_o && !fo_full) begin
        if (ew.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL word_unexpected: got %0h expected none", data_o);
        end else chk("word", 48'(data_o), 48'(ew.pop_front()));
        mwc++;
      end
    end
    @(negedge clk);
    chk("word_cnt", 48'(word_cnt), 48'(mwc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 1);
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int lim);
    bit seen;
    seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      drv(0, 0, 0, 0, 0, 1);
      cyc();
      seen = done_o;
    end
    chk(nm, 48'(seen), 48'(1));
  endtask

  initial begin
    logic [37:0] snap;
    logic [7:0] dh;
    bit vseen, hit;
    tv[0]  = '{1, 13'h1AB, 9, 0, 0, 16'h0000, 0, 0, 1, 3'd0, 16'd0};
    tv[1]  = '{1, 13'h0CD, 9, 0, 0, 16'h0000, 0, 0, 0, 3'd0, 16'd0};
    tv[2]  = '{0, 13'h000, 0, 1, 0, 16'hD5B3, 1, 0, 1, 3'd0, 16'd0};
    tv[3]  = '{0, 13'h000, 0, 1, 0, 16'hD5B3, 0, 0, 0, 3'd1, 16'd1};
    tv[4]  = '{0, 13'h000, 0, 0, 0, 16'hD5B3, 0, 0, 0, 3'd2, 16'd1};
    tv[5]  = '{0, 13'h000, 0, 0, 0, 16'hD5B3, 0, 0, 0, 3'd2, 16'd1};
    tv[6]  = '{0, 13'h000, 0, 0, 0, 16'h7000, 1, 0, 0, 3'd2, 16'd1};
    tv[7]  = '{0, 13'h000, 0, 0, 0, 16'h7000, 0, 0, 0, 3'd3, 16'd2};
    tv[8]  = '{0, 13'h000, 0, 0, 0, 16'h7000, 0, 0, 0, 3'd4, 16'd2};
    tv[9]  = '{0, 13'h000, 0, 0, 0, 16'h7000, 0, 1, 1, 3'd0, 16'd2};
    tv[10] = '{0, 13'h000, 0, 0, 0, 16'h7000, 0, 0, 1, 3'd0, 16'd2};
    @(negedge clk);
    do_reset();
    chk("reset_state", 48'(stat()), 48'({16'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0}));

    // two codes then flush, cycle by cycle
    for (int i = 0; i < 11; i++) begin
      drv(tv[i].cv, tv[i].cd, tv[i].cl, tv[i].fl, tv[i].ff, 1);
      cyc();
      chk($sformatf("vec%0d", i), 48'(stat()),
          48'({tv[i].data, tv[i].valid, tv[i].done, tv[i].ready, tv[i].st, tv[i].wc}));
    end

    // backpressure: hold the first word for 10 cycles
    do_reset();
    drv(1, 13'h1AB, 9, 0, 1, 1); cyc();
    drv(1, 13'h0CD, 9, 0, 1, 1); cyc();
    for (int i = 0; i < 10 && !valid_o; i++) begin drv(0, 0, 0, 1, 1, 1); cyc(); end
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 0, 1, 1, 1); cyc();
      chk("bp_hold", 48'({data_o, valid_o}), 48'({16'hD5B3, 1'b1}));
    end
    chk("bp_ready", 48'({code_ready, encode_out_state}), 48'({1'b0, 3'd2}));
    wait_done("bp_done", 50);
    chk("bp_words", 48'(word_cnt), 48'(2));

    // empty flush on the no-marker instance
    do_reset();
    dh = '0; vseen = 0;
    for (int k = 0; k < 8; k++) begin
      drv(0, 0, 0, k == 0, 0, 1); cyc();
      dh[k] = done1; vseen |= valid1;
    end
    chk("empty_done", 48'(dh), 48'(8'h08));
    chk("empty_valid", 48'(vseen), 48'(0));
    chk("empty_wcnt", 48'(wcnt1), 48'(0));

    // reset while DRAIN holds a word
    do_reset();
    drv(1, 13'h1AB, 9, 0, 0, 1); cyc();
    drv(1, 13'h0CD, 9, 0, 0, 1); cyc();
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      drv(0, 0, 0, 1, word_cnt != 0, 1); cyc();
      hit = encode_out_state == 3'd3;
    end
    chk("drain_reached", 48'({hit, valid_o}), 48'({1'b1, 1'b1}));
    do_reset();
    chk("midrst_state", 48'(stat()), 48'({16'h0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0}));
    drv(1, 13'h1FFF, 13, 0, 0, 1); cyc();
    drv(1, 13'h0000, 3, 0, 0, 1); cyc();
    for (int i = 0; i < 10 && !valid_o; i++) begin drv(0, 0, 0, 0, 1, 1); cyc(); end
    chk("midrst_word", 48'({data_o, valid_o}), 48'({16'hFFF8, 1'b1}));

    // clock enable freeze, length clamp and zero-length no-op
    do_reset();
    drv(1, 13'h1FFF, 15, 0, 0, 1); cyc();
    snap = stat();
    for (int i = 0; i < 5; i++) begin
      drv(1, 13'h155, 3, 1, 0, 0); cyc();
      chk("ce_freeze", 48'(stat()), 48'(snap));
    end
    drv(1, 13'h155, 0, 0, 0, 1); cyc();
    chk("len0_ready", 48'(code_ready), 48'(1));
    drv(1, 13'h1FF8, 3, 0, 0, 1); cyc();
    for (int i = 0; i < 10 && !valid_o; i++) begin drv(0, 0, 0, 0, 1, 1); cyc(); end
    chk("clamp_word", 48'({data_o, valid_o}), 48'({16'hFFF8, 1'b1}));

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drv($urandom_range(0, 1), 13'($urandom), 4'($urandom), $urandom_range(0, 40) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0);
      rst = $urandom_range(0, 999) == 0;
      cyc();
    end
    rst = 1'b0;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      hit = code_ready;
      drv(0, 0, 0, 1, 0, 1); cyc();
    end
    chk("final_flush", 48'(hit), 48'(1));
    wait_done("final_done", 60);
    chk("final_left", 48'({32'(ew.size()), 16'(bq.size())}), 48'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
